lane_packer: RTL and testbench
==============================

Name: lane_packer

Overview:
- Sequential stage that packs variable-length chunks of 12-bit lanes into dense 96-bit (8-lane) words.
- Sits directly downstream of the lane shifter datapath and consumes its lane-aligned output.
- Chunks arrive LSB-lane-first with a lane count and a last flag.
- Full words stream out through a valid/ready register stage; a last chunk forces a padded partial word out, using the shifter's 12-bit fill convention.

Parameters:
- LANE_W, 12, bits per lane
- LANES, 8, lanes per output word (word width = LANE_W*LANES = 96)
- CNT_W, 4, width of lane-count fields (must hold 0..LANES)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  chunk present
- in_ready  output  1  chunk accepted when in_valid && in_ready
- in_data  input  96  chunk lanes; lane i = in_data[12i+11:12i]; only lanes 0..in_lanes-1 meaningful
- in_lanes  input  4  lanes in chunk, 0..8
- in_last  input  1  end of packet: flush partial word after this chunk
- fill  input  12  pad value for unused lanes of a flushed word, sampled on the accepting cycle
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts when out_valid && out_ready
- out_data  output  96  packed word, oldest lane in lane 0
- out_pad  output  3  number of fill lanes at top of out_data (0 = full word)
- out_last  output  1  word is final word of packet
- err  output  1  sticky: chunk with in_lanes > 8 seen

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_pad=0, out_last=0, err=0, accumulator=0, cnt=0, state=ACC.
- State: accumulator acc (8 lanes) and cnt (0..7 lanes held).
- Accepting a chunk of k lanes:
  - Lanes are placed at positions cnt..cnt+k-1 of a 16-lane concatenation {upper, acc}.
  - If cnt+k >= 8: lanes 0..7 are emitted as a full word, lanes 8..15 become the new acc, and cnt = cnt+k-8.
  - Otherwise acc is updated and cnt = cnt+k, with no output.
- in_ready = (state==ACC) && (!out_valid || out_ready). Combinational; one output register, no bubble under continuous ready.
- Latency: a completing chunk gives out_valid on the next clk edge. Output holds stable while out_valid && !out_ready.
- in_last handling, with s = cnt+k:
  - s==0: no output.
  - 0<s<8: emit acc lanes with lanes s..7 = fill; out_pad = 8-s; out_last=1; cnt=0.
  - s==8: full word, out_pad=0, out_last=1, cnt=0.
  - s>8: emit full word (out_last=0). Go to DRAIN holding s-8 lanes and the sampled fill; in_ready=0.
- DRAIN state: when the output register is free (!out_valid || out_ready), emit the remainder padded with the sampled fill. out_pad = 16-s, out_last=1, cnt=0, return to ACC.
- in_lanes==0 without last: accepted, no state change. in_lanes==0 with last on empty acc: accepted, no output.
- in_lanes>8: accepted and dropped, err set until reset, acc/cnt unchanged.
- Lanes of in_data at index >= in_lanes are ignored (masked to fill-independent zero before merge).
- Reset mid-packet: acc, cnt, DRAIN and the pending output are discarded immediately.

Optional Feature:
- Macro: LANE_PACKER_STATS_EN.
- Defined: adds outputs stat_words (16-bit) and stat_pads (16-bit).
  - stat_words counts every out handshake.
  - stat_pads counts handshakes with out_pad!=0.
  - Both wrap at 65535->0 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Chunks of 3,3,2 lanes with lanes 0x001..0x008, out_ready=1 -> one word, lanes 0x001..0x008 in order, out_pad=0, out_last=0, on the cycle after the third chunk.
- 5 lanes then 5 lanes with last, fill=0xABC -> word1 full (lanes 1..8); DRAIN emits word2 lanes 9,10 then six 0xABC; out_pad=6, out_last=1; in_ready=0 during DRAIN.
- 2 lanes last, fill=0xFFF -> word with lanes 0,1 data, lanes 2..7=0xFFF, out_pad=6, out_last=1.
- Full 8-lane chunks back-to-back with out_ready held low 3 cycles -> out_data stable, in_ready=0; after ready, one word per cycle with no loss.
- in_lanes=9 -> err=1 and stays set; acc unchanged; following 8-lane chunk emitted intact.
- rst_n low mid-DRAIN -> out_valid=0 and cnt=0 asynchronously; next chunk starts at lane 0.

Source files
------------

// File: rtl/lane_packer.sv
// Packs variable-length chunks of 12-bit lanes into dense 8-lane words behind one output register.
// Optional LANE_PACKER_STATS_EN adds handshake and padded-word counters.
module lane_packer #(
    parameter int unsigned LANE_W = 12,
    parameter int unsigned LANES  = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANE_W*LANES-1:0]       in_data,
    input  logic [CNT_W-1:0]              in_lanes,
    input  logic                          in_last,
    input  logic [LANE_W-1:0]             fill,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANE_W*LANES-1:0]       out_data,
    output logic [$clog2(LANES)-1:0]      out_pad,
    output logic                          out_last,
    output logic                          err
`ifdef LANE_PACKER_STATS_EN
    ,
    output logic [15:0]                   stat_words,
    output logic [15:0]                   stat_pads
`endif
);

    localparam int unsigned WORD_W = LANE_W * LANES;
    localparam int unsigned PAD_W  = $clog2(LANES);
    localparam int unsigned SUM_W  = CNT_W + 1;

    typedef enum logic {
        ACC,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LANE_W-1:0]      fill_q, fill_d;
    logic                   out_valid_q, out_valid_d;
    logic [WORD_W-1:0]      out_data_q, out_data_d;
    logic [PAD_W-1:0]       out_pad_q, out_pad_d;
    logic                   out_last_q, out_last_d;
    logic                   err_q, err_d;

    logic                   out_free;
    logic                   accept;
    logic [WORD_W-1:0]      masked;
    logic [2*WORD_W-1:0]    cat;
    logic [SUM_W-1:0]       sum;

    // Replace lanes n..LANES-1 of a word with the fill value.
    function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] w,
                                                   input logic [SUM_W-1:0]  n,
                                                   input logic [LANE_W-1:0] f);
        logic [WORD_W-1:0] r;
        r = w;
        for (int i = 0; i < int'(LANES); i++) begin
            if (SUM_W'(i) >= n) r[i*LANE_W +: LANE_W] = f;
        end
        return r;
    endfunction

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == ACC) && out_free;
    assign accept   = in_valid && in_ready;
    assign sum      = SUM_W'(cnt_q) + SUM_W'(in_lanes);

    // Lanes beyond the chunk length are zeroed so acc stays clean above cnt.
    always_comb begin
        masked = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (CNT_W'(i) < in_lanes) masked[i*LANE_W +: LANE_W] = in_data[i*LANE_W +: LANE_W];
        end
        cat = {{WORD_W{1'b0}}, acc_q} | ((2*WORD_W)'(masked) << (cnt_q * LANE_W));
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_pad_d   = out_pad_q;
        out_last_d  = out_last_q;
        err_d       = err_q;

        case (state_q)
            ACC: begin
                if (accept) begin
                    if (in_lanes > CNT_W'(LANES)) begin
                        err_d = 1'b1;
                    end else if (in_last) begin
                        if (sum == '0) begin
                            cnt_d = '0;
                        end else if (sum <= SUM_W'(LANES)) begin
                            out_valid_d = 1'b1;
                            out_data_d  = pad_word(cat[WORD_W-1:0], sum, fill);
                            out_pad_d   = PAD_W'(SUM_W'(LANES) - sum);
                            out_last_d  = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                        end else begin
                            // Overflowing last chunk: full word now, remainder via DRAIN.
                            out_valid_d = 1'b1;
                            out_data_d  = cat[WORD_W-1:0];
                            out_pad_d   = '0;
                            out_last_d  = 1'b0;
                            acc_d       = cat[2*WORD_W-1:WORD_W];
                            cnt_d       = CNT_W'(sum - SUM_W'(LANES));
                            fill_d      = fill;
                            state_d     = DRAIN;
                        end
                    end else if (sum >= SUM_W'(LANES)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = cat[WORD_W-1:0];
                        out_pad_d   = '0;
                        out_last_d  = 1'b0;
                        acc_d       = cat[2*WORD_W-1:WORD_W];
                        cnt_d       = CNT_W'(sum - SUM_W'(LANES));
                    end else begin
                        acc_d = cat[WORD_W-1:0];
                        cnt_d = CNT_W'(sum);
                    end
                end
            end
            DRAIN: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pad_word(acc_q, SUM_W'(cnt_q), fill_q);
                    out_pad_d   = PAD_W'(SUM_W'(LANES) - SUM_W'(cnt_q));
                    out_last_d  = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_pad_q   <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_pad_q   <= out_pad_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_pad   = out_pad_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

`ifdef LANE_PACKER_STATS_EN
    logic [15:0] stat_words_q, stat_words_d;
    logic [15:0] stat_pads_q, stat_pads_d;

    // Counters wrap naturally at 16 bits.
    always_comb begin
        stat_words_d = stat_words_q;
        stat_pads_d  = stat_pads_q;
        if (out_valid_q && out_ready) begin
            stat_words_d = stat_words_q + 16'd1;
            if (out_pad_q != '0) stat_pads_d = stat_pads_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words_q <= '0;
            stat_pads_q  <= '0;
        end else begin
            stat_words_q <= stat_words_d;
            stat_pads_q  <= stat_pads_d;
        end
    end

    assign stat_words = stat_words_q;
    assign stat_pads  = stat_pads_q;
`endif

endmodule

// File: tb/tb_lane_packer.sv
// Directed self-checking bench for lane_packer: packing, flush/drain, backpressure, error, reset.
module tb_lane_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_data;
    logic [3:0]  in_lanes;
    logic        in_last;
    logic [11:0] fill;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic [2:0]  out_pad;
    logic        out_last;
    logic        err;
`ifdef LANE_PACKER_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_pads;
`endif

    int checks = 0;
    int errors = 0;

    lane_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_lanes  (in_lanes),
        .in_last   (in_last),
        .fill      (fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pad   (out_pad),
        .out_last  (out_last),
        .err       (err)
`ifdef LANE_PACKER_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_pads (stat_pads)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane i = base+i for i<n, other value above.
    function automatic logic [95:0] mk(input int base, input int n, input logic [11:0] other);
        logic [95:0] r;
        for (int i = 0; i < 8; i++) r[i*12 +: 12] = (i < n) ? 12'(base + i) : other;
        return r;
    endfunction

    task automatic send(input logic [95:0] d, input logic [3:0] k, input logic l, input logic [11:0] f);
        int n;
        in_data = d; in_lanes = k; in_last = l; fill = f; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_lanes = 4'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_lanes = '0; in_last = 1'b0;
        fill = '0; out_ready = 1'b1;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 96'd0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        checks++; if (out_pad !== 3'd0) begin errors++; $display("FAIL rst_out_pad got %0d exp 0", out_pad); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b exp 0", out_last); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_pack_332();
        logic [95:0] exp;
        exp = mk(1, 8, 12'h000);
        send(mk(1, 3, 12'hEEE), 4'd3, 1'b0, 12'h000);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL p332_early_valid got %b exp 0", out_valid); end
        send(mk(4, 3, 12'hEEE), 4'd3, 1'b0, 12'h000);
        send(mk(7, 2, 12'hEEE), 4'd2, 1'b0, 12'h000);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL p332_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL p332_data got %h exp %h", out_data, exp); end
        checks++; if (out_pad !== 3'd0 || out_last !== 1'b0) begin errors++; $display("FAIL p332_pad_last got %0d/%b exp 0/0", out_pad, out_last); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL p332_drop got %b exp 0", out_valid); end
    endtask

    task automatic test_drain();
        logic [95:0] exp1, exp2;
        exp1 = mk(1, 8, 12'h000);
        exp2 = mk(9, 2, 12'hABC);
        send(mk(1, 5, 12'hEEE), 4'd5, 1'b0, 12'h000);
        send(mk(6, 5, 12'hEEE), 4'd5, 1'b1, 12'hABC);
        checks++; if (out_data !== exp1 || out_valid !== 1'b1) begin errors++; $display("FAIL drain_w1 got %h v%b exp %h", out_data, out_valid, exp1); end
        checks++; if (out_last !== 1'b0 || out_pad !== 3'd0) begin errors++; $display("FAIL drain_w1_last got %b/%0d exp 0/0", out_last, out_pad); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready got %b exp 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_data !== exp2 || out_valid !== 1'b1) begin errors++; $display("FAIL drain_w2 got %h v%b exp %h", out_data, out_valid, exp2); end
        checks++; if (out_pad !== 3'd6 || out_last !== 1'b1) begin errors++; $display("FAIL drain_w2_pad got %0d/%b exp 6/1", out_pad, out_last); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_end got %b exp 0", out_valid); end
    endtask

    task automatic test_last2();
        logic [95:0] exp;
        exp = mk(12'h020, 2, 12'hFFF);
        send(mk(12'h020, 2, 12'hEEE), 4'd2, 1'b1, 12'hFFF);
        checks++; if (out_data !== exp || out_valid !== 1'b1) begin errors++; $display("FAIL last2_data got %h v%b exp %h", out_data, out_valid, exp); end
        checks++; if (out_pad !== 3'd6 || out_last !== 1'b1) begin errors++; $display("FAIL last2_pad got %0d/%b exp 6/1", out_pad, out_last); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [95:0] a, b, c;
        a = mk(12'h100, 8, 12'h000);
        b = mk(12'h200, 8, 12'h000);
        c = mk(12'h300, 8, 12'h000);
        out_ready = 1'b0;
        send(a, 4'd8, 1'b0, 12'h000);
        in_data = b; in_lanes = 4'd8; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_data !== a || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold%0d got %h exp %h", i, out_data, a); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready%0d got %b exp 0", i, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_release got %b exp 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_data !== b || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_b got %h exp %h", out_data, b); end
        in_data = c;
        @(posedge clk); #1;
        checks++; if (out_data !== c || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_c got %h exp %h", out_data, c); end
        in_valid = 1'b0; in_lanes = 4'd0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", out_valid); end
    endtask

    task automatic test_err();
        logic [95:0] exp1, exp2;
        exp1 = mk(12'h030, 8, 12'h000);
        exp2 = mk(12'h040, 8, 12'h000);
        send(mk(12'h030, 3, 12'hEEE), 4'd3, 1'b0, 12'h000);
        send(mk(12'h099, 8, 12'hEEE), 4'd9, 1'b0, 12'h000);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_no_out got %b exp 0", out_valid); end
        send(mk(12'h033, 5, 12'hEEE), 4'd5, 1'b0, 12'h000);
        checks++; if (out_data !== exp1 || out_valid !== 1'b1) begin errors++; $display("FAIL err_acc got %h exp %h", out_data, exp1); end
        send(exp2, 4'd8, 1'b0, 12'h000);
        checks++; if (out_data !== exp2 || out_valid !== 1'b1) begin errors++; $display("FAIL err_next got %h exp %h", out_data, exp2); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_drain();
        logic [95:0] exp;
        exp = mk(12'h050, 8, 12'h000);
        send(mk(1, 5, 12'hEEE), 4'd5, 1'b0, 12'h000);
        out_ready = 1'b0;
        send(mk(6, 5, 12'hEEE), 4'd5, 1'b1, 12'hABC);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rd_pre got v%b r%b exp v1 r0", out_valid, in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_async_valid got %b exp 0", out_valid); end
        checks++; if (err !== 1'b0 || out_data !== 96'd0) begin errors++; $display("FAIL rd_async_clear got err%b %h exp 0", err, out_data); end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(exp, 4'd8, 1'b0, 12'h000);
        checks++; if (out_data !== exp || out_valid !== 1'b1 || out_last !== 1'b0) begin errors++; $display("FAIL rd_next got %h l%b exp %h", out_data, out_last, exp); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_pack_332();
        test_drain();
        test_last2();
        test_back_to_back();
        test_err();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
